// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S/TDM serial audio transmitter.
package i2s_pkg;
  typedef enum logic [1:0] {FMT_I2S = 2'd0, FMT_LJ = 2'd1, FMT_RJ = 2'd2} fmt_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  // Slot bit index at which the sample MSB appears.
  function automatic int msb_offset(fmt_e fmt, int slot_width, int data_res);
    case (fmt)
      FMT_LJ:  return 0;
      FMT_RJ:  return slot_width - data_res;
      default: return 1;
    endcase
  endfunction

  // Mode code 3 is unassigned and falls back to I2S.
  function automatic fmt_e to_fmt(logic [1:0] mode);
    case (mode)
      2'd1:    return FMT_LJ;
      2'd2:    return FMT_RJ;
      default: return FMT_I2S;
    endcase
  endfunction
endpackage

// File: rtl/i2s_frame_fifo.sv
// Synchronous frame FIFO with occupancy output; no read/write bypass.
module i2s_frame_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                       mclk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge mclk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge mclk)
    if (do_push) mem[wptr] <= wdata;
endmodule

// File: rtl/i2s_tdm_tx.sv
// N-channel TDM/I2S serial transmitter driven by external SCLK-fall and frame-sync strobes.
module i2s_tdm_tx import i2s_pkg::*; #(
  parameter int DATA_RES   = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            mclk,
  input  logic                            reset,
  input  logic [1:0]                      i_mode,
  input  logic [NUM_CH*DATA_RES-1:0]      s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic                            next_sclk_fall,
  input  logic                            next_frame,
  output logic                            o_sdout,
  output logic                            o_underrun,
  output logic                            o_frame_err,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_level
);
  localparam int FW = NUM_CH * DATA_RES;
  localparam int F  = NUM_CH * SLOT_WIDTH;
  localparam int PW = (F > 1) ? $clog2(F) : 1;

  state_e          state, state_n;
  logic            pend, err_done, start, adv, ovr;
  logic [PW-1:0]   pos;
  fmt_e            fmt_q;
  logic [FW-1:0]   shadow, head, head_or_zero;
  logic            full, empty;

  function automatic logic sel_bit(logic [FW-1:0] frame, fmt_e fmt, logic [PW-1:0] p);
    int c, b, k, idx;
    logic [FW-1:0] sh;
    c = int'(p) / SLOT_WIDTH;
    b = int'(p) % SLOT_WIDTH;
    k = msb_offset(fmt, SLOT_WIDTH, DATA_RES);
    if (b >= k && b < k + DATA_RES) begin
      idx = c * DATA_RES + DATA_RES - 1 - (b - k);
      sh  = frame >> idx;
      return sh[0];
    end
    return 1'b0;
  endfunction

  assign s_ready      = !reset && !full;
  assign head_or_zero = empty ? '0 : head;

  i2s_frame_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .mclk  (mclk),
    .reset (reset),
    .push  (s_valid && s_ready),
    .wdata (s_data),
    .pop   (start),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (o_level)
  );

  always_ff @(posedge mclk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // A pending frame sync, or one arriving with the strobe, starts the frame.
  always_comb begin
    state_n = state;
    start   = next_sclk_fall && (pend || next_frame);
    adv     = next_sclk_fall && !start && (state == ST_RUN);
    ovr     = adv && (pos == PW'(F-1));
    if (start) state_n = ST_RUN;
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      pend        <= 1'b0;
      pos         <= '0;
      fmt_q       <= FMT_I2S;
      shadow      <= '0;
      err_done    <= 1'b0;
      o_sdout     <= 1'b0;
      o_underrun  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_underrun  <= start && empty;
      o_frame_err <= ovr && !err_done;
      if (start)           pend <= 1'b0;
      else if (next_frame) pend <= 1'b1;
      if (start) begin
        pos      <= '0;
        fmt_q    <= to_fmt(i_mode);
        shadow   <= head_or_zero;
        err_done <= 1'b0;
        o_sdout  <= sel_bit(head_or_zero, to_fmt(i_mode), PW'(0));
      end else if (ovr) begin
        // Counter overran the frame: hold position and mute.
        o_sdout  <= 1'b0;
        err_done <= 1'b1;
      end else if (adv) begin
        pos     <= pos + 1'b1;
        o_sdout <= sel_bit(shadow, fmt_q, pos + 1'b1);
      end
    end
  end
endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Scoreboard bench for i2s_tdm_tx: stereo instance plus an 8-channel TDM instance.
module tb_i2s_tdm_tx;
  logic        mclk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [47:0] s_data = '0;
  logic        s_valid = 1'b0, nsf = 1'b0, nfr = 1'b0;
  logic        s_ready, sdout, ur, fe;
  logic [2:0]  level;

  logic         reset8 = 1'b1;
  logic [191:0] s_data8 = '0;
  logic         sv8 = 1'b0, nsf8 = 1'b0, nfr8 = 1'b0;
  logic         rdy8, sd8, ur8, fe8;
  logic [2:0]   lvl8;

  always #5 mclk = ~mclk;

  i2s_tdm_tx dut (
    .mclk(mclk), .reset(reset), .i_mode(mode), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .next_sclk_fall(nsf), .next_frame(nfr), .o_sdout(sdout),
    .o_underrun(ur), .o_frame_err(fe), .o_level(level)
  );

  i2s_tdm_tx #(.NUM_CH(8)) dut8 (
    .mclk(mclk), .reset(reset8), .i_mode(2'd1), .s_data(s_data8), .s_valid(sv8),
    .s_ready(rdy8), .next_sclk_fall(nsf8), .next_frame(nfr8), .o_sdout(sd8),
    .o_underrun(ur8), .o_frame_err(fe8), .o_level(lvl8)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model state
  logic [47:0] mq[$];
  bit          mpend, mrun, merr, msd;
  int          mpos;
  logic [1:0]  mmode;
  logic [47:0] mfr;

  function automatic bit ebit(logic [47:0] fr, logic [1:0] md, int p);
    int slot, b, k;
    slot = p / 32;
    b    = p % 32;
    k    = (md == 2'd1) ? 0 : (md == 2'd2) ? 8 : 1;
    if (b >= k && b < k + 24) return fr[slot*24 + 23 - (b - k)];
    return 1'b0;
  endfunction

  // One mclk cycle: model predicts, DUT steps, outputs compared.
  task automatic cyc(input bit sclk, input bit nf);
    bit start, rdy, eur, efe;
    eur = 0; efe = 0;
    nsf = sclk; nfr = nf;
    #1;
    rdy = !reset && (mq.size() < 4);
    chk("s_ready", s_ready, rdy);
    if (!reset) begin
      start = sclk && (mpend || nf);
      if (start) begin
        mpend = 0; mrun = 1; mpos = 0; mmode = mode; merr = 0;
        if (mq.size() > 0) mfr = mq.pop_front();
        else begin mfr = '0; eur = 1; end
        msd = ebit(mfr, mmode, 0);
      end else begin
        if (nf) mpend = 1;
        if (sclk && mrun) begin
          if (mpos == 63) begin msd = 0; efe = !merr; merr = 1; end
          else begin mpos++; msd = ebit(mfr, mmode, mpos); end
        end
      end
      if (s_valid && rdy) mq.push_back(s_data);
    end
    @(posedge mclk); #1;
    nsf = 0; nfr = 0;
    if (reset) begin
      mq.delete(); mpend = 0; mrun = 0; merr = 0; mpos = 0; msd = 0;
    end
    chk("sdout", sdout, msd);
    chk("underrun", ur, eur);
    chk("frame_err", fe, efe);
    chk("level", level, mq.size());
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin cyc(1, 0); cyc(0, 0); end
  endtask

  task automatic push(input logic [47:0] d);
    s_data = d; s_valid = 1; cyc(0, 0); s_valid = 0;
  endtask

  typedef struct {
    logic [1:0]  md;
    logic [23:0] l, r;
    int          k;   // slot bit carrying the left-channel MSB
  } vec_t;
  vec_t tbl[4];

  task automatic step8();
    @(posedge mclk); #1;
  endtask

  function automatic bit exp8(int p);
    int c, b;
    c = p / 32; b = p % 32;
    if (b < 24) return ((c + 1) >> (23 - b)) & 1;
    return 1'b0;
  endfunction

  initial begin
    tbl[0] = '{2'd0, 24'hA5A5A5, 24'h5A5A5A, 1};
    tbl[1] = '{2'd1, 24'h800001, 24'h123456, 0};
    tbl[2] = '{2'd2, 24'hFFFFFF, 24'h000001, 8};
    tbl[3] = '{2'd3, 24'hABCDEF, 24'hFEDCBA, 1};

    // Reset, then an idle strobe that must be ignored
    reset = 1; cyc(0, 0); cyc(0, 0);
    reset = 0; cyc(0, 0);
    cyc(1, 0); cyc(0, 0);

    // Table of formats
    foreach (tbl[v]) begin
      mode = tbl[v].md;
      push({tbl[v].r, tbl[v].l});
      cyc(1, 1);
      if (tbl[v].k == 0) chk("msb_pos", sdout, tbl[v].l[23]);
      for (int p = 1; p < 64; p++) begin
        cyc(0, 0); cyc(1, 0);
        if (p == tbl[v].k) chk("msb_pos", sdout, tbl[v].l[23]);
      end
    end

    // Underrun, frame pushed mid-frame goes out next
    mode = 0;
    cyc(1, 1);
    chk("underrun_pulse", ur, 1);
    cyc(0, 0);
    push(48'h123456_ABCDEF);
    strobes(63);
    cyc(1, 1); strobes(63);

    // Full FIFO: 5th frame waits for the next pop
    for (int i = 0; i < 5; i++) begin
      s_data = {$urandom, $urandom}; s_valid = 1; cyc(0, 0);
    end
    chk("full_ready", s_ready, 0);
    chk("full_level", level, 4);
    cyc(1, 1);
    chk("pop_level", level, 3);
    cyc(0, 0);
    chk("held_accept", level, 4);
    s_valid = 0;
    strobes(63);
    for (int i = 0; i < 4; i++) begin cyc(1, 1); strobes(63); end

    // Frame sync 3 cycles ahead of the sclk strobe; mode change mid-frame
    push(48'hC0FFEE_BADA55);
    cyc(0, 1); cyc(0, 0); cyc(0, 0);
    cyc(1, 0);
    strobes(20);
    mode = 2;
    strobes(43);
    push(48'h000001_777777);
    cyc(1, 1); strobes(63);

    // Overrun: RJ last bit is 1, then the counter runs past the frame
    push(48'h000001_000001);
    cyc(1, 1); strobes(63);
    chk("last_bit", sdout, 1);
    cyc(1, 0);
    chk("overrun_err", fe, 1);
    chk("overrun_mute", sdout, 0);
    cyc(0, 0); strobes(1);

    // Push into empty FIFO during frame start: underrun, frame kept
    mode = 0;
    s_data = 48'hFACE01_0BEEF0; s_valid = 1;
    cyc(1, 1);
    s_valid = 0;
    chk("nobypass_level", level, 1);
    strobes(63);
    cyc(1, 1); strobes(63);

    // Reset mid-frame
    push(48'h111111_222222);
    cyc(1, 1); strobes(10);
    push(48'h333333_444444);
    reset = 1; cyc(0, 0); reset = 0;
    chk("rst_level", level, 0);
    cyc(1, 0);

    // 8-channel TDM, left-justified, channel c = c+1
    reset8 = 1; step8(); reset8 = 0;
    for (int c = 0; c < 8; c++) s_data8[c*24 +: 24] = 24'(c + 1);
    sv8 = 1; step8(); step8(); sv8 = 0;
    chk("tdm_level", lvl8, 2);
    nsf8 = 1; nfr8 = 1; step8(); nsf8 = 0; nfr8 = 0;
    chk("tdm_pos0", sd8, exp8(0));
    chk("tdm_ur", ur8, 0);
    for (int p = 1; p <= 100; p++) begin
      nsf8 = 1; step8(); nsf8 = 0;
      if (p % 32 >= 19 && p % 32 <= 24) chk("tdm_bit", sd8, exp8(p));
      step8();
    end
    chk("tdm_level1", lvl8, 1);
    reset8 = 1; step8(); reset8 = 0;
    chk("tdm_rst_sdout", sd8, 0);
    chk("tdm_rst_level", lvl8, 0);
    sv8 = 1; step8(); sv8 = 0;
    nsf8 = 1; step8(); nsf8 = 0;
    chk("tdm_idle_sdout", sd8, 0);
    chk("tdm_idle_nopop", lvl8, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/i2s_tdm_tx.md
# i2s_tdm_tx

Parametrised serial audio transmitter. Generalises the stereo I2S transmitter to N-channel TDM frames, configurable slot width and three justification formats, with a frame FIFO and a valid/ready input handshake. It sits between the audio datapath and the pad, in the mclk domain. SCLK and LRCLK/FSYNC are generated elsewhere and arrive as one-cycle "next edge" strobes.

## Interface
- DATA_RES, 24, sample bits per channel.
- SLOT_WIDTH, 32, SCLK periods per channel slot; must be ≥ DATA_RES+1.
- NUM_CH, 2, channels per frame; range 1..8. Slot 0 is left when NUM_CH=2.
- FIFO_DEPTH, 4, frames buffered; must be a power of 2 and ≥ 2.

- mclk  input  1  master clock; all logic on posedge.
- reset  input  1  reset, synchronous, active-high.
- i_mode  input  2  format: 0 = I2S (1-bit delay), 1 = left-justified, 2 = right-justified, 3 = treated as I2S.
- s_data  input  NUM_CH*DATA_RES  one frame; channel c is s_data[c*DATA_RES +: DATA_RES].
- s_valid  input  1  frame offered.
- s_ready  output  1  FIFO can accept a frame.
- next_sclk_fall  input  1  strobe: the SCLK falling edge occurs at this mclk edge.
- next_frame  input  1  strobe: the frame sync (LRCLK fall) occurs at this mclk edge.
- o_sdout  output  1  serial data.
- o_underrun  output  1  one-cycle pulse: a frame started with the FIFO empty.
- o_frame_err  output  1  one-cycle pulse: the bit counter overran the frame length.
- o_level  output  $clog2(FIFO_DEPTH+1)  FIFO occupancy.

## Operation
- Frame = NUM_CH slots × SLOT_WIDTH bits; position counter pos runs 0..F-1, where F = NUM_CH*SLOT_WIDTH.
- States:
  - IDLE (after reset): o_sdout = 0; the bit strobe is ignored.
  - RUN: entered at the first frame start.
- next_frame sets a pending flag. The frame start executes on the next next_sclk_fall, including one in the same cycle. Frame start does the following:
  - pos ← 0.
  - Latch i_mode for the whole frame.
  - Pop the FIFO head into the shadow register. If the FIFO is empty, load zeros and pulse o_underrun.
  - Clear the pending flag.
- next_sclk_fall without a frame start, in RUN: pos ← pos+1 and o_sdout ← the bit for the new pos.
- At pos = F-1, pos saturates: o_sdout = 0 and o_frame_err pulses once per frame.
- Bit mapping for slot bit b within slot c:
  - MSB offset k = 1 (I2S), 0 (LJ), or SLOT_WIDTH-DATA_RES (RJ).
  - For k ≤ b < k+DATA_RES, output ch_c[DATA_RES-1-(b-k)]; otherwise output 0.
- FIFO behaviour:
  - s_ready = !full.
  - Push on s_valid && s_ready. Pop only at frame start.
  - There is no bypass path. A push into an empty FIFO in the same cycle as a frame start still underruns, and the pushed frame is kept.
  - A push and a pop in the same cycle leave o_level unchanged.
- A change to i_mode mid-frame takes effect at the next frame start.

## Timing
- Reset values:
  - o_sdout=0, s_ready=0 during reset and 1 the cycle after.
  - o_underrun=0, o_frame_err=0, o_level=0.
  - State IDLE, pending flag 0, pos 0, shadow 0.
- o_sdout is registered and changes on the mclk edge at which next_sclk_fall is high, which is coincident with the SCLK fall.
- A frame accepted at edge t is transmitted from the first frame start at or after edge t+1.
- o_level updates on the edge after a push or pop.
- Reset asserted mid-frame: on the next edge o_sdout=0, the FIFO is flushed and the state returns to IDLE.

## Structure
- Package i2s_pkg:
  - enum fmt_e {FMT_I2S=0, FMT_LJ=1, FMT_RJ=2}.
  - Function msb_offset(fmt, SLOT_WIDTH, DATA_RES).
- Sub-module i2s_frame_fifo: synchronous FIFO, width NUM_CH*DATA_RES, depth FIFO_DEPTH, with level output.
- Top module: FSM, pending flag, pos counter, shadow register and bit select.

## Test plan
1. I2S, 24/32/2: push L=0xA5A5A5, R=0x5A5A5A, then frame start. Expect pos0=0, pos1..24 = 0xA5A5A5 MSB-first, pos25..32=0, pos33..56 = 0x5A5A5A, pos57..63=0.
2. LJ: L=0x800001 gives pos0=1, pos23=1, all other slot-0 bits 0. RJ: L=0xFFFFFF gives pos0..7=0, pos8..31=1.
3. Underrun: frame start with an empty FIFO gives a one-cycle o_underrun pulse and 64 zero bits. A frame pushed during that frame is sent in the next one and o_level returns to 0.
4. Full: push 5 frames with no frame start. Expect o_level=4, s_ready=0, and the 5th frame held. It is accepted the cycle after the next frame-start pop.
5. Strobe ordering and errors:
   - next_frame 3 cycles before next_sclk_fall: frame starts at the sclk strobe.
   - 65 sclk strobes without a frame: one o_frame_err pulse and o_sdout=0.
   - i_mode switched mid-frame: applies at the next frame only.
6. TDM NUM_CH=8, SLOT_WIDTH=32, LJ, channel c = c+1: slot c MSB at pos 32c, value c+1 in slot c. Reset asserted at pos 100: next edge o_sdout=0, o_level=0, IDLE.
